keypad_scanner: RTL and testbench

//  Scans a 4x4 matrix keypad by driving one row low at a time and sampling the pulled-up columns.

---
 rtl/keypad_scanner_if.sv | 19 +
 rtl/keypad_scanner.sv | 158 +++++++++++++++
 tb/tb_keypad_scanner.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_if.sv
// Keypad-side signal bundle for keypad_scanner: row drive, column sense and the
// debounced key report (row/col one-hot plus level enable) consumed by the decoder.
interface keypad_scanner_if;
  logic [3:0] col_n;
  logic [3:0] row_drv_n;
  logic [3:0] row;
  logic [3:0] col;
  logic       en;

  modport master (
    input  col_n,
    output row_drv_n, row, col, en
  );

  modport slave (
    output col_n,
    input  row_drv_n, row, col, en
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with 2-flop column synchronizer and press/release debounce.
// Optional KEYPAD_GHOST_REJECT_EN rejects multi-key columns instead of priority-reducing them.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  keypad_scanner_if.master kp
);

  localparam int unsigned DW  = $clog2(SCAN_DIV);
  localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DBW-1:0] DBC_LAST   = DBW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t         state, state_nxt;
  logic [3:0]     col_meta, col_sync;
  logic [3:0]     colv, colk;
  logic           hit, match;
  logic [DW-1:0]  dwell, dwell_nxt;
  logic [DBW-1:0] dbc, dbc_nxt;
  logic [3:0]     row_drv_n, row_drv_nxt, row_adv;
  logic [3:0]     cand_row, cand_row_nxt, cand_col, cand_col_nxt;
  logic [3:0]     row_q, row_nxt, col_q, col_nxt;
  logic           en_q, en_nxt;

  assign colv    = ~col_sync;
  assign row_adv = {row_drv_n[2:0], row_drv_n[3]};

`ifdef KEYPAD_GHOST_REJECT_EN
  logic multi;
  // A multi-bit colv never equals the one-hot candidate, so it mismatches naturally.
  assign multi = (colv & (colv - 4'd1)) != '0;
  assign colk  = colv;
  assign hit   = (colv != '0) && !multi;
`else
  assign colk  = colv & (~colv + 4'd1);
  assign hit   = colk != '0;
`endif

  assign match = (colk == cand_col);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_meta  <= '1;
      col_sync  <= '1;
      state     <= SCAN;
      dwell     <= '0;
      dbc       <= '0;
      row_drv_n <= 4'b1110;
      cand_row  <= '0;
      cand_col  <= '0;
      row_q     <= '0;
      col_q     <= '0;
      en_q      <= 1'b0;
    end else begin
      col_meta  <= kp.col_n;
      col_sync  <= col_meta;
      state     <= state_nxt;
      dwell     <= dwell_nxt;
      dbc       <= dbc_nxt;
      row_drv_n <= row_drv_nxt;
      cand_row  <= cand_row_nxt;
      cand_col  <= cand_col_nxt;
      row_q     <= row_nxt;
      col_q     <= col_nxt;
      en_q      <= en_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    dwell_nxt    = dwell;
    dbc_nxt      = dbc;
    row_drv_nxt  = row_drv_n;
    cand_row_nxt = cand_row;
    cand_col_nxt = cand_col;
    row_nxt      = row_q;
    col_nxt      = col_q;
    en_nxt       = en_q;
    case (state)
      SCAN: begin
        if (dwell == DWELL_LAST) begin
          if (hit) begin
            cand_row_nxt = ~row_drv_n;
            cand_col_nxt = colk;
            dbc_nxt      = '0;
            state_nxt    = DEBOUNCE;
          end else begin
            row_drv_nxt = row_adv;
            dwell_nxt   = '0;
          end
        end else begin
          dwell_nxt = dwell + DW'(1);
        end
      end
      DEBOUNCE: begin
        if (match) begin
          if (dbc == DBC_LAST) begin
            state_nxt = HELD;
            row_nxt   = cand_row;
            col_nxt   = cand_col;
            en_nxt    = 1'b1;
          end else begin
            dbc_nxt = dbc + DBW'(1);
          end
        end else begin
          state_nxt   = SCAN;
          row_drv_nxt = row_adv;
          dwell_nxt   = '0;
        end
      end
      HELD: begin
        if (!match) begin
          state_nxt = RELEASE;
          dbc_nxt   = '0;
        end
      end
      RELEASE: begin
        if (match) begin
          state_nxt = HELD;
          dbc_nxt   = '0;
        end else if (dbc == DBC_LAST) begin
          state_nxt   = SCAN;
          en_nxt      = 1'b0;
          row_nxt     = '0;
          col_nxt     = '0;
          row_drv_nxt = row_adv;
          dwell_nxt   = '0;
        end else begin
          dbc_nxt = dbc + DBW'(1);
        end
      end
      default: begin
        state_nxt = SCAN;
        en_nxt    = 1'b0;
        row_nxt   = '0;
        col_nxt   = '0;
        dwell_nxt = '0;
        dbc_nxt   = '0;
      end
    endcase
  end

  assign kp.row_drv_n = row_drv_n;
  assign kp.row       = row_q;
  assign kp.col       = col_q;
  assign kp.en        = en_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad matrix model drives col_n from row_drv_n,
// stimulus queues expected output changes, a negedge monitor pops and checks them.
module tb_keypad_scanner;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  keypad_scanner_if kif();

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kif)
  );

  // keys[r][c] = 1 means the key at row r, column c is pressed
  logic [3:0][3:0] keys;
  logic [3:0]      col_model;

  always_comb begin
    col_model = '1;
    for (int r = 0; r < 4; r++)
      if (!kif.row_drv_n[r]) col_model = col_model & ~keys[r];
  end
  assign kif.col_n = col_model;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [8:0]  val;
    int unsigned at;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  bit          mon_on = 1'b0;
  logic [8:0]  prev = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic expect_out(input logic e, input logic [3:0] r, input logic [3:0] c,
                            input int unsigned at);
    exp_t x;
    x.val = {e, r, c};
    x.at  = at;
    sb.push_back(x);
  endtask

  task automatic wait_until(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_row(input logic [3:0] target, output int unsigned e);
    int unsigned k;
    k = 0;
    @(negedge clk);
    while (kif.row_drv_n !== target && k < 64) begin
      @(negedge clk);
      k++;
    end
    if (k >= 64) check("row_wait_timeout", kif.row_drv_n, target);
    e = cyc;
  endtask

  // Monitor: any change of {en,row,col} must match the next queued expectation and cycle.
  always @(negedge clk) begin
    logic [8:0] cur;
    exp_t       x;
    if (mon_on) begin
      cur = {kif.en, kif.row, kif.col};
      if (cur !== prev) begin
        if (sb.size() == 0) begin
          check("unexpected_output_change", cur, prev);
        end else begin
          x = sb.pop_front();
          check("out_value", cur, x.val);
          check("out_latency", cyc, x.at);
        end
        prev = cur;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned base, e, r, c, d;
    logic [3:0]  exp_row;

    keys = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_row_drv", kif.row_drv_n, 4'b1110);
    check("reset_outputs", {kif.en, kif.row, kif.col}, 9'h000);
    reset = 1'b1;
    base = cyc;
    mon_on = 1'b1;

    // 1: idle rotation, 4 clk per row
    for (int n = 0; n < 20; n++) begin
      exp_row = ~(4'b0001 << ((n / 4) % 4));
      check("scan_rotation", kif.row_drv_n, exp_row);
      @(negedge clk);
    end

    // 2: clean press row2/col1, hold, release
    keys[2][1] = 1'b1;
    wait_row(4'b1011, e);
    expect_out(1'b1, 4'b0100, 4'b0010, e + 12);
    wait_until(e + 62);
    check("held_row_frozen", kif.row_drv_n, 4'b1011);
    check("held_outputs", {kif.en, kif.row, kif.col}, {1'b1, 4'b0100, 4'b0010});
    keys[2][1] = 1'b0;
    r = cyc;
    expect_out(1'b0, 4'b0000, 4'b0000, r + 11);
    wait_until(r + 11);
    check("release_row_advance", kif.row_drv_n, 4'b0111);

    // 3: press bounce aborts debounce
    keys[2][0] = 1'b1;
    wait_row(4'b1011, e);
    wait_until(e + 3);
    keys[2][0] = 1'b0;
    wait_until(e + 5);
    check("bounce_row_frozen", kif.row_drv_n, 4'b1011);
    wait_until(e + 6);
    check("bounce_abort_advance", kif.row_drv_n, 4'b0111);
    wait_until(e + 20);
    check("bounce_no_en", kif.en, 1'b0);

    // 4: release bounce absorbed, final release drops en
    keys[1][3] = 1'b1;
    wait_row(4'b1101, e);
    expect_out(1'b1, 4'b0010, 4'b1000, e + 12);
    wait_until(e + 15);
    keys[1][3] = 1'b0;
    r = cyc;
    wait_until(r + 5);
    keys[1][3] = 1'b1;
    wait_until(r + 25);
    check("rel_bounce_outputs", {kif.en, kif.row, kif.col}, {1'b1, 4'b0010, 4'b1000});
    check("rel_bounce_row_frozen", kif.row_drv_n, 4'b1101);
    keys = '0;
    r = cyc;
    expect_out(1'b0, 4'b0000, 4'b0000, r + 11);
    wait_until(r + 11);
    check("rel_final_row_advance", kif.row_drv_n, 4'b1011);

    // 5: two keys on row0, cols 0 and 2
    keys[0][0] = 1'b1;
    keys[0][2] = 1'b1;
    wait_row(4'b1110, e);
`ifdef KEYPAD_GHOST_REJECT_EN
    wait_until(e + 4);
    check("ghost_rotate", kif.row_drv_n, 4'b1101);
    wait_until(e + 20);
    check("ghost_no_en", kif.en, 1'b0);
    keys = '0;
`else
    expect_out(1'b1, 4'b0001, 4'b0001, e + 12);
    wait_until(e + 14);
    keys = '0;
    r = cyc;
    expect_out(1'b0, 4'b0000, 4'b0000, r + 11);
    wait_until(r + 11);
`endif

    // 6: async reset mid-HELD, then re-detect after full debounce
    keys[3][2] = 1'b1;
    wait_row(4'b0111, e);
    expect_out(1'b1, 4'b1000, 4'b0100, e + 12);
    wait_until(e + 20);
    c = cyc;
    #2;
    expect_out(1'b0, 4'b0000, 4'b0000, c + 1);
    reset = 1'b0;
    #1;
    check("async_reset_outputs", {kif.en, kif.row, kif.col}, 9'h000);
    check("async_reset_row_drv", kif.row_drv_n, 4'b1110);
    repeat (3) @(negedge clk);
    check("reset_hold_row_drv", kif.row_drv_n, 4'b1110);
    reset = 1'b1;
    d = cyc;
    expect_out(1'b1, 4'b1000, 4'b0100, d + 24);
    wait_until(d + 30);
    keys = '0;
    r = cyc;
    expect_out(1'b0, 4'b0000, 4'b0000, r + 11);
    wait_until(r + 13);

    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
